mul_seq: RTL

Parametrised multi-cycle integer multiplier for the mini-processor ALU. It produces a 2·WIDTH-bit product from two WIDTH-bit operands, one iteration per clock, using a single internal adder. It sits beside the combinational ALU datapath and feeds the 64-bit result-select mux. It replaces the unrolled adder-array multiply path with a start/done handshake that the bus controller can stall on.

---
 rtl/mul_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-add / radix-2 Booth multiplier, one iteration per clock.
// Define MUL_SEQ_SIGNED_EN to enable signed (Booth) operation selected by op_signed.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_start,
  input  logic                 op_clear,
  input  logic                 op_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 op_busy,
  output logic                 op_done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     a_reg;
  logic [2*WIDTH:0]     p_reg;
  logic [2*WIDTH:0]     p_nxt;
  logic [WIDTH:0]       upper;
  logic [WIDTH:0]       sum;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 last_iter;

`ifdef MUL_SEQ_SIGNED_EN
  logic                 mode_reg;
  logic                 q_prev;
`else
  logic                 unused_signed;
  assign unused_signed = op_signed;
`endif

  assign accept    = op_start && !op_clear && (state == IDLE || state == DONE);
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign upper     = p_reg[2*WIDTH:WIDTH];

  // One iteration: conditional add/subtract into the upper WIDTH+1 bits, then shift right.
  always_comb begin
    sum   = upper;
    p_nxt = p_reg;
`ifdef MUL_SEQ_SIGNED_EN
    if (mode_reg) begin
      case ({p_reg[0], q_prev})
        2'b01:   sum = upper + {a_reg[WIDTH-1], a_reg};
        2'b10:   sum = upper - {a_reg[WIDTH-1], a_reg};
        default: sum = upper;
      endcase
      p_nxt = {sum[WIDTH], sum, p_reg[WIDTH-1:1]};
    end else begin
      sum   = p_reg[0] ? (upper + {1'b0, a_reg}) : upper;
      p_nxt = {1'b0, sum, p_reg[WIDTH-1:1]};
    end
`else
    sum   = p_reg[0] ? (upper + {1'b0, a_reg}) : upper;
    p_nxt = {1'b0, sum, p_reg[WIDTH-1:1]};
`endif
  end

  always_comb begin
    state_nxt = state;
    op_busy   = 1'b0;
    op_done   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: begin
        op_busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        op_done   = 1'b1;
        state_nxt = accept ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (op_clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_reg  <= '0;
      p_reg  <= '0;
      cnt    <= '0;
      result <= '0;
`ifdef MUL_SEQ_SIGNED_EN
      mode_reg <= 1'b0;
      q_prev   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (op_clear) begin
        cnt    <= '0;
        result <= '0;
      end else if (accept) begin
        a_reg <= multiplicand;
        p_reg <= {{(WIDTH+1){1'b0}}, multiplier};
        cnt   <= '0;
`ifdef MUL_SEQ_SIGNED_EN
        mode_reg <= op_signed;
        q_prev   <= 1'b0;
`endif
      end else if (state == EXEC) begin
        p_reg <= p_nxt;
`ifdef MUL_SEQ_SIGNED_EN
        q_prev <= p_reg[0];
`endif
        // Result is written only on the edge that enters DONE; the guard bit is dropped.
        if (last_iter) begin
          result <= p_nxt[2*WIDTH-1:0];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
